// File: rtl/axi_pkg.sv
// Shared AXI read-side constants and types for the BRAM read responder.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'd0;
  localparam logic [1:0] AXI_BURST_INCR  = 2'd1;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'd2;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;

  localparam int AXI_R_DATA_WIDTH = 32;

  typedef struct packed {
    logic [AXI_R_DATA_WIDTH-1:0] data;
    logic [1:0]                  resp;
    logic                        last;
  } r_beat_t;

  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_DRAIN} rd_state_e;

endpackage

// File: rtl/axi_read_address_channel.sv
// AXI4 AR channel bundle; the slave drives only arready.
interface axi_read_address_channel #(
  parameter int AXI_ARID_WIDTH   = 1,
  parameter int AXI_ARADDR_WIDTH = 32,
  parameter int AXI_ARUSER_WIDTH = 0
);
  localparam int UW = (AXI_ARUSER_WIDTH > 0) ? AXI_ARUSER_WIDTH : 1;

  logic [AXI_ARID_WIDTH-1:0]   arid;
  logic [AXI_ARADDR_WIDTH-1:0] araddr;
  logic [7:0]                  arlen;
  logic [2:0]                  arsize;
  logic [1:0]                  arburst;
  logic [UW-1:0]               aruser;
  logic                        arvalid;
  logic                        arready;

  modport master (output arid, araddr, arlen, arsize, arburst, aruser, arvalid,
                  input  arready);
  modport slave  (input  arid, araddr, arlen, arsize, arburst, aruser, arvalid,
                  output arready);
endinterface

// File: rtl/axi_r_skid_fifo.sv
// Two-entry register FIFO holding R beats between the BRAM and the R channel.
module axi_r_skid_fifo #(
  parameter type beat_t = axi_pkg::r_beat_t
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       push,
  input  beat_t      push_beat,
  input  logic       rready,
  output logic       valid,
  output beat_t      head,
  output logic [1:0] count
);
  beat_t      mem_q [2];
  beat_t      mem_d [2];
  logic       rd_q, rd_d, wr_q, wr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       pop;

  assign valid = (cnt_q != 2'd0);
  assign head  = mem_q[rd_q];
  assign count = cnt_q;
  assign pop   = valid && rready;

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    if (push) begin
      mem_d[wr_q] = push_beat;
      wr_d        = ~wr_q;
    end
    if (pop) rd_d = ~rd_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      mem_q <= '{default: '0};
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/axi_bram_read_responder.sv
// AXI4 read responder: walks FIXED/INCR/WRAP bursts over a 1-cycle BRAM and
// returns beats through a 2-entry FIFO with full R-channel backpressure.
module axi_bram_read_responder
  import axi_pkg::*;
#(
  parameter int AXI_ARID_WIDTH   = 1,
  parameter int AXI_ARADDR_WIDTH = 32,
  parameter int AXI_ARUSER_WIDTH = 0,
  parameter int AXI_DATA_WIDTH   = 32,
  parameter int MEM_ADDR_WIDTH   = 10
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  axi_read_address_channel.slave    ar,
  output logic [AXI_ARID_WIDTH-1:0] rid,
  output logic [AXI_DATA_WIDTH-1:0] rdata,
  output logic [1:0]                rresp,
  output logic                      rlast,
  output logic                      rvalid,
  input  logic                      rready,
  output logic                      mem_en,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic [AXI_DATA_WIDTH-1:0] mem_rdata
);
  localparam int LSB = $clog2(AXI_DATA_WIDTH / 8);
  localparam int AW  = AXI_ARADDR_WIDTH;

  typedef struct packed {
    logic [AXI_DATA_WIDTH-1:0] data;
    logic [1:0]                resp;
    logic                      last;
  } beat_t;

  rd_state_e                 state_q, state_d;
  logic [AXI_ARID_WIDTH-1:0] id_q, id_d;
  logic [AW-1:0]             addr_q, addr_d;
  logic [7:0]                len_q, len_d;
  logic [2:0]                size_q, size_d;
  logic [1:0]                burst_q, burst_d;
  logic                      err_q, err_d;
  logic [8:0]                remain_q, remain_d;
  logic                      inflight_q, inflight_d;
  logic                      infl_last_q, infl_last_d;
  logic                      arready_en_q, arready_en_d;

  logic          issue, pop, req_err;
  logic [2:0]    credit_used;
  logic [1:0]    fifo_count;
  logic [AW-1:0] step, wrap_mask, next_addr;
  beat_t         push_beat, head;
  logic          unused_aruser;

  assign unused_aruser = ^ar.aruser;
  assign ar.arready    = (state_q == ST_IDLE) && arready_en_q;
  assign pop           = rvalid && rready;
  // Credit the beat leaving this cycle so rready=1 sustains one beat per cycle.
  assign credit_used   = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};

  assign req_err = (ar.arburst == 2'd3) || (ar.arsize > 3'(LSB)) ||
                   ((ar.arburst == AXI_BURST_WRAP) &&
                    !(ar.arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));

  always_comb begin
    step      = AW'(1) << size_q;
    wrap_mask = ((AW'({1'b0, len_q}) + AW'(1)) << size_q) - AW'(1);
    case (burst_q)
      AXI_BURST_FIXED: next_addr = addr_q;
      AXI_BURST_WRAP:  next_addr = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
      default:         next_addr = addr_q + step;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    addr_d       = addr_q;
    len_d        = len_q;
    size_d       = size_q;
    burst_d      = burst_q;
    err_d        = err_q;
    remain_d     = remain_q;
    arready_en_d = 1'b1;
    issue        = 1'b0;
    case (state_q)
      ST_IDLE: if (ar.arvalid && arready_en_q) begin
        id_d     = ar.arid;
        addr_d   = ar.araddr;
        len_d    = ar.arlen;
        size_d   = ar.arsize;
        burst_d  = ar.arburst;
        err_d    = req_err;
        remain_d = {1'b0, ar.arlen} + 9'd1;
        state_d  = ST_BURST;
      end
      ST_BURST: if (credit_used < 3'd2) begin
        issue    = 1'b1;
        addr_d   = next_addr;
        remain_d = remain_q - 9'd1;
        if (remain_q == 9'd1) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (fifo_count == 2'd0 && !inflight_q) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    inflight_d  = issue;
    infl_last_d = issue && (remain_q == 9'd1);
  end

  // Error bursts still flow through the in-flight stage so beat timing is uniform.
  assign mem_en   = issue && !err_q;
  assign mem_addr = addr_q[LSB +: MEM_ADDR_WIDTH];

  always_comb begin
    push_beat.data = err_q ? '0 : mem_rdata;
    push_beat.resp = err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    push_beat.last = infl_last_q;
  end

  axi_r_skid_fifo #(.beat_t(beat_t)) u_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push      (inflight_q),
    .push_beat (push_beat),
    .rready    (rready),
    .valid     (rvalid),
    .head      (head),
    .count     (fifo_count)
  );

  assign rdata = head.data;
  assign rresp = head.resp;
  assign rlast = head.last;
  assign rid   = id_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      id_q         <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      err_q        <= 1'b0;
      remain_q     <= '0;
      inflight_q   <= 1'b0;
      infl_last_q  <= 1'b0;
      arready_en_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      err_q        <= err_d;
      remain_q     <= remain_d;
      inflight_q   <= inflight_d;
      infl_last_q  <= infl_last_d;
      arready_en_q <= arready_en_d;
    end
  end
endmodule

// File: tb/tb_axi_bram_read_responder.sv
// Scoreboard bench: stimulus queues expected beats/addresses, a negedge monitor checks.
module tb_axi_bram_read_responder;
  logic        aclk = 1'b0;
  logic        aresetn;
  logic        rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic        mem_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata = '0;

  axi_read_address_channel #(.AXI_ARID_WIDTH(1), .AXI_ARADDR_WIDTH(32), .AXI_ARUSER_WIDTH(0)) ar_if ();

  axi_bram_read_responder dut (
    .aclk(aclk), .aresetn(aresetn), .ar(ar_if.slave),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 aclk = ~aclk;

  // BRAM model: word[n] = n, one-cycle read latency.
  always @(posedge aclk) if (mem_en) mem_rdata <= 32'(mem_addr);

  int unsigned cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int          total = 0, bad = 0;
  logic [35:0] exp_q [$];
  int unsigned ea_q [$];
  logic        mem_chk = 1'b1;
  logic        lat_arm = 1'b0;
  int unsigned hs_cyc = 0;
  logic        stall_prev = 1'b0;
  logic [36:0] held = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic exp_beat(input logic [31:0] d, input logic [1:0] r, input logic l, input logic id);
    exp_q.push_back({id, l, r, d});
  endtask

  always @(negedge aclk) begin
    if (!aresetn) stall_prev = 1'b0;
    else begin
      if (mem_chk && mem_en)
        check("mem_addr", 64'(mem_addr), (ea_q.size() != 0) ? 64'(ea_q.pop_front()) : 64'hDEAD_0000);
      if (stall_prev) check("r_stable", 64'({rvalid, rid, rlast, rresp, rdata}), 64'(held));
      if (lat_arm && rvalid) begin
        check("latency", 64'(cyc - hs_cyc), 64'd3);
        lat_arm = 1'b0;
      end
      if (rvalid && rready)
        check("r_beat", 64'({rid, rlast, rresp, rdata}),
              (exp_q.size() != 0) ? 64'(exp_q.pop_front()) : 64'hBAD_0000_0000);
      check("fifo_le2", 64'(dut.fifo_count <= 2'd2), 64'd1);
      stall_prev = rvalid && !rready;
      held       = {rvalid, rid, rlast, rresp, rdata};
    end
  end

  task automatic send_ar(input logic id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    logic ok = 1'b0;
    @(posedge aclk); #1;
    ar_if.arid = id; ar_if.araddr = addr; ar_if.arlen = len;
    ar_if.arsize = size; ar_if.arburst = burst; ar_if.arvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (ar_if.arready) begin hs_cyc = cyc; lat_arm = 1'b1; ok = 1'b1; break; end
    end
    check("ar_handshake", 64'(ok), 64'd1);
    @(posedge aclk); #1;
    ar_if.arvalid = 1'b0;
  endtask

  task automatic wait_done(input logic toggle);
    for (int k = 0; k < 300; k++) begin
      @(posedge aclk); #1;
      if (toggle) rready = (k % 4 == 0) || (k % 4 == 3);
      if (exp_q.size() == 0 && ea_q.size() == 0) break;
    end
    rready = 1'b1;
    check("drain_beats", 64'(exp_q.size()), 64'd0);
    check("drain_addrs", 64'(ea_q.size()), 64'd0);
    exp_q.delete(); ea_q.delete();
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge aclk);
        if (ar_if.arready) begin seen = 1'b1; break; end
      end
      check("arready_idle", 64'(seen), 64'd1);
    end
  endtask

  initial begin
    int unsigned wrap_w [4];
    wrap_w = '{14, 15, 12, 13};
    aresetn = 1'b0; rready = 1'b1;
    ar_if.arvalid = 1'b0; ar_if.arid = '0; ar_if.araddr = '0; ar_if.arlen = '0;
    ar_if.arsize = '0; ar_if.arburst = '0; ar_if.aruser = '0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_arready", 64'(ar_if.arready), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rlast", 64'(rlast), 64'd0);
    check("rst_rresp", 64'(rresp), 64'd0);
    check("rst_rid", 64'(rid), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_mem_en", 64'(mem_en), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    @(posedge aclk); #1 aresetn = 1'b1;

    // INCR 0x10 len3: words 4..7
    for (int i = 0; i < 4; i++) begin ea_q.push_back(4 + i); exp_beat(32'(4 + i), 2'd0, i == 3, 1'b1); end
    send_ar(1'b1, 32'h10, 8'd3, 3'd2, 2'd1); wait_done(1'b0);

    // WRAP 0x38 len3: 0x38,0x3C,0x30,0x34
    for (int i = 0; i < 4; i++) begin ea_q.push_back(wrap_w[i]); exp_beat(32'(wrap_w[i]), 2'd0, i == 3, 1'b0); end
    send_ar(1'b0, 32'h38, 8'd3, 3'd2, 2'd2); wait_done(1'b0);

    // FIXED 0x20 len2: word 8 three times
    for (int i = 0; i < 3; i++) begin ea_q.push_back(8); exp_beat(32'd8, 2'd0, i == 2, 1'b1); end
    send_ar(1'b1, 32'h20, 8'd2, 3'd2, 2'd0); wait_done(1'b0);

    // INCR 0x100 len7 under rready 1,0,0,1 backpressure
    for (int i = 0; i < 8; i++) begin ea_q.push_back(64 + i); exp_beat(32'(64 + i), 2'd0, i == 7, 1'b0); end
    send_ar(1'b0, 32'h100, 8'd7, 3'd2, 2'd1); wait_done(1'b1);

    // Reserved burst type: two SLVERR beats, no BRAM access
    exp_beat(32'd0, 2'd2, 1'b0, 1'b1); exp_beat(32'd0, 2'd2, 1'b1, 1'b1);
    send_ar(1'b1, 32'h40, 8'd1, 3'd2, 2'd3); wait_done(1'b0);

    // Oversized arsize: one SLVERR beat
    exp_beat(32'd0, 2'd2, 1'b1, 1'b0);
    send_ar(1'b0, 32'h0, 8'd0, 3'd3, 2'd1); wait_done(1'b0);

    // WRAP with illegal length 3 beats: SLVERR on all
    for (int i = 0; i < 3; i++) exp_beat(32'd0, 2'd2, i == 2, 1'b1);
    send_ar(1'b1, 32'h8, 8'd2, 3'd2, 2'd2); wait_done(1'b1);

    // Reset after beat 2 of an 8-beat burst
    mem_chk = 1'b0;
    exp_beat(32'd0, 2'd0, 1'b0, 1'b1); exp_beat(32'd1, 2'd0, 1'b0, 1'b1);
    send_ar(1'b1, 32'h0, 8'd7, 3'd2, 2'd1);
    begin
      logic got2 = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(posedge aclk); #1;
        if (exp_q.size() == 0) begin got2 = 1'b1; break; end
      end
      check("pre_reset_beats", 64'(got2), 64'd1);
    end
    aresetn = 1'b0; rready = 1'b0;
    @(posedge aclk); #1 aresetn = 1'b1; rready = 1'b1;
    @(negedge aclk);
    check("post_rst_rvalid", 64'(rvalid), 64'd0);
    check("post_rst_arready", 64'(ar_if.arready), 64'd0);
    @(negedge aclk);
    check("post_rst_arready_up", 64'(ar_if.arready), 64'd1);
    exp_q.delete(); ea_q.delete(); mem_chk = 1'b1; lat_arm = 1'b0;
    ea_q.push_back(16); exp_beat(32'd16, 2'd0, 1'b1, 1'b0);
    send_ar(1'b0, 32'h40, 8'd0, 3'd2, 2'd1); wait_done(1'b0);
    repeat (5) @(posedge aclk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
